data_memory_arbiter: RTL and testbench

Shares the single-port data memory (address_rw / data_in / data_out / memory_write_enable) between two requesters. Requester 0 is the processor core; requester 1 is the network/DMA interface that loads and unloads message buffers. The block sits between both requesters and the data memory. It does round-robin arbitration with a bounded burst length, issues one memory transaction per cycle, and returns read data with a registered valid strobe.

---
 rtl/data_memory_arbiter.sv | 128 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// The processor (requester 0) and the network/DMA interface (requester 1) share the memory.
// Arbitration is round-robin with a bounded burst length.
// At most one transaction is issued per cycle, and read data returns with a registered valid strobe.
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester 0 (processor)
    input  logic                  req_0,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  gnt_0,
    output logic                  rvalid_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    // requester 1 (network / DMA)
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_1,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    // data memory
    output logic [ADDR_WIDTH-1:0] address_rw,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  memory_write_enable,
    input  logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] BURST_LIMIT = CNT_WIDTH'(MAX_BURST);

    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_0_q, pend_0_d;
    logic                 pend_1_q, pend_1_d;
    logic                 win_1_c;
    logic                 gnt_any_c;

    // Contention winner: after an idle cycle or at the burst limit the owner switches.
    // Otherwise the current burst continues.
    always_comb begin
        win_1_c = last_q;
        if ((cnt_q == '0) || (cnt_q >= BURST_LIMIT)) begin
            win_1_c = ~last_q;
        end
    end

    // Grant decode; nothing is granted while reset is asserted.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (!rst) begin
            if (req_0 && req_1) begin
                gnt_0 = ~win_1_c;
                gnt_1 = win_1_c;
            end else begin
                gnt_0 = req_0;
                gnt_1 = req_1;
            end
        end
    end

    assign gnt_any_c = gnt_0 | gnt_1;

    // Memory port mux: the granted requester drives the memory, otherwise all zero.
    always_comb begin
        address_rw          = '0;
        data_in             = '0;
        memory_write_enable = 1'b0;
        if (gnt_0) begin
            address_rw          = addr_0;
            data_in             = wdata_0;
            memory_write_enable = we_0;
        end else if (gnt_1) begin
            address_rw          = addr_1;
            data_in             = wdata_1;
            memory_write_enable = we_1;
        end
    end

    // Next state: burst owner/count bookkeeping and read-in-flight flags.
    always_comb begin
        last_d   = last_q;
        cnt_d    = cnt_q;
        pend_0_d = gnt_0 & ~we_0;
        pend_1_d = gnt_1 & ~we_1;
        if (gnt_any_c) begin
            if (gnt_1 == last_q) begin
                if (cnt_q < BURST_LIMIT) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end else begin
                cnt_d  = CNT_WIDTH'(1);
                last_d = gnt_1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; reset makes requester 0 win the first contention and drops reads in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            cnt_q    <= '0;
            pend_0_q <= 1'b0;
            pend_1_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            pend_0_q <= pend_0_d;
            pend_1_q <= pend_1_d;
        end
    end

    // Read return: the valid strobe is the registered pending flag, and the data is gated by it.
    assign rvalid_0 = pend_0_q;
    assign rvalid_1 = pend_1_q;
    assign rdata_0  = pend_0_q ? data_out : '0;
    assign rdata_1  = pend_1_q ? data_out : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized self-checking bench for data_memory_arbiter with a grant-history reference model.
module tb_data_memory_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic [AW-1:0] address_rw;
    logic [DW-1:0] data_in;
    logic          memory_write_enable;
    logic [DW-1:0] data_out;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    int            hist[$];
    int            last_w;
    int            n_pass   = 0;
    int            n_checks = 0;

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_0(req[0]), .we_0(we[0]), .addr_0(addr[0]), .wdata_0(wdata[0]),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req[1]), .we_1(we[1]), .addr_1(addr[1]), .wdata_1(wdata[1]),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .address_rw(address_rw), .data_in(data_in),
        .memory_write_enable(memory_write_enable), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears one cycle after the address
    always @(posedge clk) begin
        if (memory_write_enable) mem[address_rw] <= data_in;
        data_out <= mem[address_rw];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Winner from the grant history: prev owner = most recent granted requester (1 after reset),
    // run = length of the unbroken run of grants to it ending in the previous cycle.
    function automatic int model_winner();
        int prev = 1;
        int run  = 0;
        if (!req[0] && !req[1]) return -1;
        if (req[0] != req[1]) return req[1] ? 1 : 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != -1) begin
                prev = hist[i];
                break;
            end
        end
        for (int i = hist.size() - 1; i >= 0 && hist[i] == prev; i--) run++;
        if (run == 0 || run >= int'(MB)) return 1 - prev;
        return prev;
    endfunction

    task automatic new_txn(input int k, input logic is_read);
        we[k]    = is_read ? 1'b0 : ($urandom_range(0, 2) == 0);
        addr[k]  = ($urandom_range(0, 1) == 1) ? AW'(16'h0200 + 16'($urandom_range(0, 15))) : AW'($urandom);
        wdata[k] = DW'($urandom);
    endtask

    // One cycle: check the combinational grant and memory port, advance, then check the read return.
    task automatic cycle();
        int            w;
        logic          nrv [2];
        logic [DW-1:0] nrd [2];
        #1;
        w = model_winner();
        check("gnt_0", 32'(gnt_0), 32'(w == 0));
        check("gnt_1", 32'(gnt_1), 32'(w == 1));
        nrv[0] = 1'b0; nrv[1] = 1'b0; nrd[0] = '0; nrd[1] = '0;
        if (w >= 0) begin
            check("address_rw", 32'(address_rw), 32'(addr[w]));
            check("mem_we", 32'(memory_write_enable), 32'(we[w]));
            if (we[w]) begin
                check("data_in", 32'(data_in), 32'(wdata[w]));
                ref_mem[addr[w]] = wdata[w];
            end else begin
                nrv[w] = 1'b1;
                nrd[w] = ref_mem[addr[w]];
            end
        end else begin
            check("idle_addr", 32'(address_rw), 32'(0));
            check("idle_we", 32'(memory_write_enable), 32'(0));
            check("idle_din", 32'(data_in), 32'(0));
        end
        hist.push_back(w);
        last_w = w;
        @(posedge clk);
        #1;
        check("rvalid_0", 32'(rvalid_0), 32'(nrv[0]));
        check("rdata_0", 32'(rdata_0), 32'(nrd[0]));
        check("rvalid_1", 32'(rvalid_1), 32'(nrv[1]));
        check("rdata_1", 32'(rdata_1), 32'(nrd[1]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt_0"}, 32'(gnt_0), 32'(0));
        check({tag, "_gnt_1"}, 32'(gnt_1), 32'(0));
        check({tag, "_rvalid_0"}, 32'(rvalid_0), 32'(0));
        check({tag, "_rvalid_1"}, 32'(rvalid_1), 32'(0));
        check({tag, "_rdata_0"}, 32'(rdata_0), 32'(0));
        check({tag, "_rdata_1"}, 32'(rdata_1), 32'(0));
        check({tag, "_addr"}, 32'(address_rw), 32'(0));
        check({tag, "_din"}, 32'(data_in), 32'(0));
        check({tag, "_we"}, 32'(memory_write_enable), 32'(0));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        last_w = -1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        last_w = -1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b1; we[k] = 1'b1; addr[k] = AW'(16'h55); wdata[k] = DW'(16'h77);
        end

        // Reset with both requests high: every output must stay zero
        rst = 1'b1;
        #12;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;

        // First read after release returns 0xBEEF one cycle later
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = AW'(16'h0010);
        req[1] = 1'b0;
        rst = 1'b0;
        cycle();
        check("beef_read", 32'(rdata_0), 32'(16'hBEEF));

        // Network write, then read back the same word
        req[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = AW'(16'h0200); wdata[1] = DW'(16'h1234);
        cycle();
        we[1] = 1'b0;
        cycle();
        check("wr_rd_back", 32'(rdata_1), 32'(16'h1234));
        req[1] = 1'b0;

        // Continuous contention from reset: bounded bursts alternate
        do_reset("rst_burst");
        req[0] = 1'b1; req[1] = 1'b1;
        new_txn(0, 1'b1); new_txn(1, 1'b1);
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (last_w >= 0) new_txn(last_w, 1'b1);
        end

        // Requester 0 alone saturates its count, then loses the first contention
        req[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            new_txn(0, 1'b1);
        end
        req[1] = 1'b1; new_txn(1, 1'b1);
        cycle();
        check("sat_switch", 32'(last_w), 32'(1));
        new_txn(1, 1'b1);
        cycle();

        // Idle cycle with last=0: next contention grants requester 1
        req[1] = 1'b0;
        cycle();
        cycle();
        req[0] = 1'b0;
        cycle();
        req[0] = 1'b1; req[1] = 1'b1;
        new_txn(0, 1'b1); new_txn(1, 1'b1);
        cycle();
        check("idle_rr", 32'(last_w), 32'(1));

        // Reset right after a granted read: the read is dropped
        req[1] = 1'b0; req[0] = 1'b1; we[0] = 1'b0;
        #1;
        check("pre_rst_gnt_0", 32'(gnt_0), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        hist.delete();
        last_w = -1;
        #1;
        check("post_rst_rvalid_0", 32'(rvalid_0), 32'(0));
        req[1] = 1'b1;
        new_txn(0, 1'b1); new_txn(1, 1'b1);
        cycle();
        check("post_rst_first", 32'(last_w), 32'(0));

        // Random traffic with holds, withdrawals and idle gaps
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (last_w == k) begin
                    req[k] = ($urandom_range(0, 9) < 7);
                    new_txn(k, 1'b0);
                end else if (!req[k]) begin
                    req[k] = ($urandom_range(0, 1) == 1);
                    if (req[k]) new_txn(k, 1'b0);
                end else if ($urandom_range(0, 19) == 0) begin
                    req[k] = 1'b0;
                end
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
